fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 32-bit RISC-V core. Owns the program counter, drives the address of the combinational instruction memory, and captures each returned word with its PC into a small instruction buffer that feeds decode through a valid/ready handshake. Sits between the branch/jump resolution logic, which supplies redirects, and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- DEPTH, 2, instruction buffer entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address to instruction memory; equals PC
- imem_rd  in  32  instruction word returned combinationally for imem_addr
- redirect_en  in  1  one-cycle pulse: taken branch/jump/trap
- redirect_pc  in  32  new PC; bits [1:0] forced to 0 internally
- id_valid  out  1  buffer head holds a valid instruction
- id_ready  in  1  decode accepts head this cycle
- id_instr  out  32  head instruction
- id_pc  out  32  head PC
- id_pc_plus4  out  32  id_pc + 4, mod 2^32
- halted  out  1  fetch stopped after ECALL/EBREAK

## Operation
- States: RUN and HALT.
- pop = id_valid & id_ready.
- push = RUN & ~redirect_en & (count < DEPTH | pop).
- On push: write {imem_rd, pc} at tail and set pc <= pc + 4, wrapping at 2^32.
- Simultaneous push and pop at count == DEPTH is legal; count is unchanged.
- Halt detection: if a pushed word equals 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK), the next state is HALT.
  - In HALT: no pushes and the PC holds.
  - The buffer keeps draining to decode.
- Redirect has highest priority:
  - count <= 0, head/tail pointers reset.
  - pc <= {redirect_pc[31:2], 2'b00}; state <= RUN.
  - A coincident pop is discarded and no push occurs that cycle.
  - Decode must treat the head as killed when issuing redirect_en.
- halted = (state == HALT) & (count == 0).
- id_* are driven from the buffer head. When id_valid = 0 the values are don't-care but stable; no X propagates.

## Timing
- Reset values:
  - pc = RESET_PC, imem_addr = RESET_PC, state = RUN, count = 0.
  - id_valid = 0, id_instr = 0, id_pc = 0, id_pc_plus4 = 4, halted = 0.
- Fetch-to-decode latency is 1 cycle: the word at PC p is pushed on edge N and id_valid/id_pc = p are visible after edge N.
- Sustained throughput is 1 instruction per cycle with id_ready held high.
- id_ready low for k cycles: the buffer fills in at most DEPTH cycles, then the PC holds. No instruction is lost or duplicated.
- Redirect at edge N: id_valid = 0 after N; the first instruction from redirect_pc appears after N+1.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first push occurs on the first rising edge with rst high.

## Structure
- Shared package riscv_pkg holds:
  - ECALL/EBREAK encodings
  - instruction width (32)
  - the default RESET_PC
  - state encoding (RUN = 1'b0, HALT = 1'b1)
- One sub-module, fetch_fifo: synchronous FIFO of DEPTH × 64 bits ({pc, instr}).
  - Ports: push, pop, flush, full, empty, count, head data.
  - fetch_stage contains the PC register, state machine and push/redirect logic.

## Test plan
- Reset/stream: release rst with id_ready = 1 and a program of NOPs 32'h0000_0013 → id_pc = 0, 4, 8, … on consecutive cycles; id_pc_plus4 = id_pc + 4.
- Backpressure: hold id_ready = 0 for 5 cycles from PC 0x10 → imem_addr stops at 0x18. On release, the delivered PCs are exactly 0x10, 0x14, 0x18, … with no gap or duplicate.
- Redirect with pop: assert redirect_en with redirect_pc = 0x0000_0103 while id_valid & id_ready → next cycle id_valid = 0; following cycle id_pc = 0x100.
- Halt: ECALL at 0x20 → 0x20 is delivered, no fetch beyond 0x24, halted = 1 once drained. A later redirect to 0x40 clears halted and resumes fetch.
- Reset mid-stream: drop rst while count = 2 → id_valid = 0 and imem_addr = RESET_PC immediately, before the next clock edge.
- PC wrap: redirect to 0xFFFF_FFFC → the next delivered PC is 0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared definitions for the RV32 core front end: instruction
//                width, SYSTEM encodings that stop fetch, default reset PC
//                and the fetch state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_W          = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [31:0] INSTR_ECALL      = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK     = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // True for the two instructions after which fetch must stop.
    function automatic logic is_halt_instr(input logic [INSTR_W-1:0] instr);
        return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous instruction buffer, DEPTH entries of WIDTH bits.
//                Head entry is presented combinationally. A flush empties the
//                buffer and returns both pointers to zero, overriding any
//                push or pop in the same cycle.
//  Ports       : clk, rst (async, active low)
//                push / wr_data    - write wr_data at tail
//                pop               - retire head entry
//                flush             - discard all entries
//                full, empty, count, head_data - status and head entry
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,            // power of two, >= 2
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_q;

    logic push_ok;
    logic pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[head_ptr];

    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle; pops of an empty buffer are ignored.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Storage is cleared on reset so the head output is a known zero value
    // before the first push (keeps id_* free of X at reset).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok && !flush) begin
            mem[tail_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : RV32 instruction fetch. Holds the PC, addresses the
//                combinational instruction memory, buffers {pc, instr} pairs
//                towards decode and stops fetching after ECALL/EBREAK until
//                the next redirect.
//  Ports       : clk, rst (async, active low)
//                imem_addr / imem_rd            - instruction memory
//                redirect_en / redirect_pc      - branch/jump/trap redirect
//                id_valid / id_ready            - decode handshake
//                id_instr / id_pc / id_pc_plus4 - head instruction
//                halted                         - stopped and fully drained
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,   // bits [1:0] = 0
    parameter int          DEPTH    = 2                   // power of two, >= 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [XLEN-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_rd,
    input  logic                redirect_en,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [XLEN-1:0]     id_pc,
    output logic [XLEN-1:0]     id_pc_plus4,
    output logic                halted
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = XLEN + INSTR_W;

    fetch_state_e          state;
    fetch_state_e          state_next;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_next;
    logic [XLEN-1:0]       redirect_target;

    logic                  push;
    logic                  pop;
    logic                  buf_full;
    logic                  buf_empty;
    logic [CNT_W-1:0]      buf_count;
    logic [ENT_W-1:0]      buf_head;

    assign redirect_target = redirect_pc & ~32'h0000_0003;

    assign imem_addr = pc;
    assign id_valid  = ~buf_empty;
    assign pop       = id_valid & id_ready;

    // Redirect wins over everything: no push and the coincident pop is
    // swallowed by the flush inside the buffer.
    assign push = (state == ST_RUN) & ~redirect_en & (~buf_full | pop);

    // ------------------------------------------------------------------
    // State and PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect_en) begin
            state_next = ST_RUN;
            pc_next    = redirect_target;
        end else if (push) begin
            pc_next = pc + 32'd4;          // wraps modulo 2^32
            if (is_halt_instr(imem_rd)) begin
                state_next = ST_HALT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_en),
        .wr_data   ({pc, imem_rd}),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count),
        .head_data (buf_head)
    );

    assign id_pc       = buf_head[ENT_W-1:INSTR_W];
    assign id_instr    = buf_head[INSTR_W-1:0];
    assign id_pc_plus4 = id_pc + 32'd4;

    assign halted = (state == ST_HALT) & (buf_count == '0);

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;

    logic        sys_on;      // places ECALL at 0x20 and EBREAK at 0x44
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .halted      (halted)
    );

    // Instruction memory model
    always_comb begin
        imem_rd = NOP;
        if (sys_on && imem_addr == 32'h0000_0020) imem_rd = ECALL;
        if (sys_on && imem_addr == 32'h0000_0044) imem_rd = EBREAK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse redirect for one cycle; returns at the falling edge after the
    // redirect edge.
    task automatic do_redirect(input logic [31:0] target);
        redirect_en = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        id_ready    = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        sys_on      = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_valid",  {31'b0, id_valid}, 32'd0);
        check("rst_instr",  id_instr,          32'd0);
        check("rst_pc",     id_pc,             32'd0);
        check("rst_pc4",    id_pc_plus4,       32'd4);
        check("rst_halted", {31'b0, halted},   32'd0);
        check("rst_addr",   imem_addr,         32'd0);

        // Stream of NOPs at one per cycle
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("str_valid", {31'b0, id_valid}, 32'd1);
            check("str_pc",    id_pc,             32'(i * 4));
            check("str_pc4",   id_pc_plus4,       32'(i * 4 + 4));
            check("str_instr", id_instr,          NOP);
        end
        check("str_addr", imem_addr, 32'h14);

        // Backpressure: head 0x10 held, fetch stops at 0x18
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_pc", id_pc, 32'h10);
        end
        check("bp_addr", imem_addr, 32'h18);
        id_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("bp_drain_pc", id_pc, 32'(32'h10 + i * 4));
        end

        // Redirect with coincident pop, unaligned target
        check("rd_pre_valid", {31'b0, id_valid}, 32'd1);
        do_redirect(32'h0000_0103);
        check("rd_valid0", {31'b0, id_valid}, 32'd0);
        check("rd_addr",   imem_addr,         32'h100);
        @(negedge clk);
        check("rd_valid1", {31'b0, id_valid}, 32'd1);
        check("rd_pc",     id_pc,             32'h100);
        check("rd_pc4",    id_pc_plus4,       32'h104);

        // Halt on ECALL at 0x20
        sys_on = 1'b1;
        do_redirect(32'h0000_0018);
        check("h_valid0", {31'b0, id_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("h_pc", id_pc, 32'(32'h18 + i * 4));
        end
        @(negedge clk);
        check("h_ecall_pc",    id_pc,           32'h20);
        check("h_ecall_instr", id_instr,        ECALL);
        check("h_not_halted",  {31'b0, halted}, 32'd0);
        check("h_addr",        imem_addr,       32'h24);
        @(negedge clk);
        check("h_drained", {31'b0, id_valid}, 32'd0);
        check("h_halted",  {31'b0, halted},   32'd1);
        check("h_addr2",   imem_addr,         32'h24);
        @(negedge clk);
        check("h_halted2", {31'b0, halted},   32'd1);
        check("h_addr3",   imem_addr,         32'h24);

        // Redirect out of HALT, then EBREAK at 0x44
        do_redirect(32'h0000_0040);
        check("hr_halted", {31'b0, halted}, 32'd0);
        @(negedge clk);
        check("hr_pc", id_pc, 32'h40);
        @(negedge clk);
        check("eb_pc",    id_pc,    32'h44);
        check("eb_instr", id_instr, EBREAK);
        @(negedge clk);
        check("eb_halted", {31'b0, halted}, 32'd1);
        check("eb_addr",   imem_addr,       32'h48);
        sys_on = 1'b0;

        // Asynchronous reset with two entries buffered
        do_redirect(32'h0000_0200);
        @(negedge clk);
        check("mr_pc", id_pc, 32'h200);
        id_ready = 1'b0;
        @(negedge clk);
        check("mr_full_addr", imem_addr, 32'h208);
        rst = 1'b0;
        #1;
        check("mr_valid", {31'b0, id_valid}, 32'd0);
        check("mr_addr",  imem_addr,         32'd0);
        @(negedge clk);
        rst      = 1'b1;
        id_ready = 1'b1;
        @(negedge clk);
        check("mr_restart_valid", {31'b0, id_valid}, 32'd1);
        check("mr_restart_pc",    id_pc,             32'd0);

        // PC wrap at 2^32
        do_redirect(32'hFFFF_FFFC);
        check("wr_valid0", {31'b0, id_valid}, 32'd0);
        @(negedge clk);
        check("wr_pc_top", id_pc,       32'hFFFF_FFFC);
        check("wr_pc4",    id_pc_plus4, 32'h0000_0000);
        @(negedge clk);
        check("wr_pc_zero", id_pc, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
